data_mem_responder: RTL

Word-addressed data memory that answers the CPU's data port: address, write data, enable and write-enable in; read data out. It sits beside the CPU at the top level, on the opposite end of the data-memory interface. It holds a synchronous single-port RAM plus a small memory-mapped I/O window. The window provides a 64-bit cycle counter, a scratch register and a tohost mailbox for simulation exit and status.

---
 rtl/data_mem_responder_if.sv | 13 +
 rtl/data_mem_responder.sv | 61 ++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: CPU data-port bus between the CPU and the data memory responder
interface data_mem_responder_if;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        misalign;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    modport master(output en, we, addr, wdata, input rdata, misalign, tohost_valid, tohost_data);
    modport slave(input en, we, addr, wdata, output rdata, misalign, tohost_valid, tohost_data);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data RAM plus MMIO window (cycle counter, tohost, scratch)
module data_mem_responder #(
    parameter int         DEPTH_LOG2    = 10,
    parameter logic [3:0] MMIO_BASE_NIB = 4'h1
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    logic [31:0] mem_q [1<<DEPTH_LOG2];
    logic [31:0] rdata_q, rdata_d, tohost_data_q, tohost_data_d, scratch_q, scratch_d, hi_q, hi_d, mmio_rdata;
    logic [63:0] cnt_q, cnt_d;
    logic        misalign_q, misalign_d, pend_q, pend_d, tohost_valid_q, tohost_valid_d;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]  off;
    logic        mis, mmio, rd, wr;
    always_comb begin
        idx            = bus.addr[DEPTH_LOG2+1:2];
        off            = bus.addr[3:2];
        mis            = bus.en & |bus.addr[1:0];
        mmio           = bus.addr[31:28] == MMIO_BASE_NIB;
        rd             = bus.en & ~bus.we & ~mis;
        wr             = bus.en & bus.we & ~mis;
        mmio_rdata     = off == 2'd0 ? cnt_q[31:0] : off == 2'd1 ? hi_q : off == 2'd2 ? tohost_data_q : scratch_q;
        rdata_d        = mis ? 32'd0 : rd ? (mmio ? mmio_rdata : mem_q[idx]) : rdata_q;
        hi_d           = (rd & mmio & off == 2'd0) ? cnt_q[63:32] : hi_q;
        pend_d         = wr & mmio & off == 2'd2;
        tohost_data_d  = pend_d ? bus.wdata : tohost_data_q;
        scratch_d      = (wr & mmio & off == 2'd3) ? bus.wdata : scratch_q;
        tohost_valid_d = pend_q;
        misalign_d     = mis;
        cnt_d          = cnt_q + 64'd1;
    end
    always_ff @(posedge clk)
        if (!rst && wr && !mmio) mem_q[idx] <= bus.wdata;
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q        <= '0;
            misalign_q     <= 1'b0;
            pend_q         <= 1'b0;
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= '0;
            scratch_q      <= '0;
            hi_q           <= '0;
            cnt_q          <= '0;
        end else begin
            rdata_q        <= rdata_d;
            misalign_q     <= misalign_d;
            pend_q         <= pend_d;
            tohost_valid_q <= tohost_valid_d;
            tohost_data_q  <= tohost_data_d;
            scratch_q      <= scratch_d;
            hi_q           <= hi_d;
            cnt_q          <= cnt_d;
        end
    end
    assign bus.rdata        = rdata_q;
    assign bus.misalign     = misalign_q;
    assign bus.tohost_valid = tohost_valid_q;
    assign bus.tohost_data  = tohost_data_q;
endmodule
